sram_mem_controller: RTL and testbench
======================================

# sram_mem_controller

Memory-stage responder for the pipelined ARM core. It accepts the load/store requests the decode path generates (mem_r_en for LDR, mem_w_en for STR, with the ADD-computed byte address). It serves each 32-bit word as two 16-bit accesses to an external SRAM and holds the pipeline via ready until the access completes. It sits between the EXE/MEM pipeline register and the off-chip SRAM pins.

## Interface
Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- ACCESS_CYCLES, 2: clock cycles per 16-bit SRAM half-access; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_r_en  in  1  load request; held stable while ready=0.
- mem_w_en  in  1  store request; held stable while ready=0.
- address  in  32  byte address of the access.
- write_data  in  32  store data.
- read_data  out  32  load result; registered.
- ready  out  1  combinational; 0 stalls (freezes) the pipeline.
- sram_addr  out  18  SRAM halfword address; registered.
- sram_dq_out  out  16  data driven to SRAM; registered.
- sram_dq_oe  out  1  1 = controller drives the SRAM data bus.
- sram_dq_in  in  16  data returned from SRAM.
- sram_we_n  out  1  SRAM write strobe, active-low.

## Operation
- Word index is idx = (address - BASE_ADDR) >> 2, computed modulo 2^32. address[1:0] is ignored.
- The low half uses sram_addr = {idx[16:0], 1'b0}, carrying data bits [15:0].
- The high half uses sram_addr = {idx[16:0], 1'b1}, carrying data bits [31:16].
- Requests are sampled only in IDLE. If mem_r_en and mem_w_en are both 1, the access is a write.
- Address, write_data and the access type are latched when the request is accepted. Later input changes are ignored until IDLE.
- The state machine has four states: IDLE, LOW, HIGH, DONE.
  - IDLE -> LOW when a request is present.
  - LOW -> HIGH after ACCESS_CYCLES cycles.
  - HIGH -> DONE after ACCESS_CYCLES cycles.
  - DONE -> IDLE unconditionally.
- One cycle counter counts 0..ACCESS_CYCLES-1 and clears on every state entry.
- Writes:
  - In LOW, sram_dq_oe=1, sram_we_n=0 and sram_dq_out=data[15:0].
  - In HIGH, the same outputs apply with sram_dq_out=data[31:16].
  - sram_we_n=1 in IDLE and DONE.
- Reads:
  - sram_we_n=1 and sram_dq_oe=0 throughout.
  - sram_dq_in is captured on the last cycle of LOW (low half) and the last cycle of HIGH (high half).
  - read_data = {high, low} is updated on entry to DONE. It holds until the next read completes; writes never change it.
- ready:
  - In IDLE, ready = !(mem_r_en | mem_w_en).
  - In LOW and HIGH, ready = 0.
  - In DONE, ready = 1.
- A request dropped mid-access (a protocol violation) still completes using the latched values.

## Timing
- Reset values: state IDLE, counter 0, read_data 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1. ready is 1 when no request is present.
- Request first seen in cycle 0 (IDLE):
  - ready is 0 for cycles 0..2*ACCESS_CYCLES.
  - ready is 1 in cycle 2*ACCESS_CYCLES+1 (DONE), which is 5 with the default.
  - The pipeline advances on the edge that ends DONE.
- The earliest next request is accepted in the cycle after DONE, so there is no overlap. Back-to-back accesses cost 2*ACCESS_CYCLES+2 cycles each.
- read_data is valid from the DONE cycle onward.
- Reset asserted mid-access returns all registers to reset values immediately, without waiting for a clock edge. sram_we_n goes high asynchronously. The access is abandoned and leaves no partial read_data update.

## Test plan
- Idle: no request for 10 cycles after reset -> ready=1 throughout, sram_we_n=1, sram_dq_oe=0, read_data=0.
- Store then load at 1024:
  - Store 0xDEADBEEF -> SRAM halfword 0 = 0xBEEF, halfword 1 = 0xDEAD; ready low for exactly 5 cycles.
  - Load from 1024 -> read_data=0xDEADBEEF in DONE.
- Address mapping: load from 1036 -> sram_addr 6 during LOW, 7 during HIGH.
  - Load from 1039 gives the same addresses.
  - With ACCESS_CYCLES=3, ready stays low for 7 cycles.
- Simultaneous requests: mem_r_en=mem_w_en=1, address 1028, data 0x12345678 -> a write occurs to halfwords 2/3 and read_data is unchanged.
- Reset mid-store: assert rst on the 2nd cycle of HIGH -> sram_we_n=1 and state IDLE without a clock edge. The next load from the same address returns the new low half with the old high half.
- Back-to-back: store 0x00000001 then load of 0x0000CAFE preloaded at 1032, the load presented on the cycle after DONE -> each access takes 6 cycles and read_data=0x0000CAFE.

Source files
------------

// File: rtl/sram_mem_controller_if.sv
// Pipeline-side request/response bus between the EXE/MEM register and the SRAM controller.
// The pipeline (master) drives the request and the controller (slave) returns data and ready.
interface sram_mem_controller_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output mem_r_en, mem_w_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  mem_r_en, mem_w_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_mem_controller.sv
// Memory-stage responder: each 32-bit load/store is split into two 16-bit SRAM accesses
// (low half first), and the pipeline is stalled through ready until the word completes.
module sram_mem_controller #(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    sram_mem_controller_if.slave    bus,
    output logic [17:0]             sram_addr,
    output logic [15:0]             sram_dq_out,
    output logic                    sram_dq_oe,
    input  logic [15:0]             sram_dq_in,
    output logic                    sram_we_n
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        req;
    logic        last;
    logic [16:0] word_idx;
    logic        is_wr;
    logic [15:0] wr_hi;
    logic [15:0] rd_lo;

    assign req      = bus.mem_r_en | bus.mem_w_en;
    assign last     = (cnt == LAST_CNT);
    assign word_idx = 17'((bus.address - BASE_ADDR) >> 2);

    always_comb begin
        state_nx  = state;
        bus.ready = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = !req;
                if (req) state_nx = LOW;
            end
            LOW:  if (last) state_nx = HIGH;
            HIGH: if (last) state_nx = DONE;
            DONE: begin
                bus.ready = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The counter restarts on every state change; IDLE and DONE never count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state || state == IDLE || state == DONE)
                cnt <= '0;
            else
                cnt <= cnt + 4'd1;
        end
    end

    // SRAM pins are registered from the transition into each state, so they are
    // already valid in the first cycle of LOW/HIGH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.read_data <= '0;
            sram_addr     <= '0;
            sram_dq_out   <= '0;
            sram_dq_oe    <= 1'b0;
            sram_we_n     <= 1'b1;
            is_wr         <= 1'b0;
            wr_hi         <= '0;
            rd_lo         <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    is_wr       <= bus.mem_w_en;
                    wr_hi       <= bus.write_data[31:16];
                    sram_addr   <= {word_idx, 1'b0};
                    sram_dq_out <= bus.write_data[15:0];
                    sram_dq_oe  <= bus.mem_w_en;
                    sram_we_n   <= !bus.mem_w_en;
                end
                LOW: if (last) begin
                    sram_addr[0] <= 1'b1;
                    sram_dq_out  <= wr_hi;
                    if (!is_wr) rd_lo <= sram_dq_in;
                end
                HIGH: if (last) begin
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                    if (!is_wr) bus.read_data <= {sram_dq_in, rd_lo};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench: a word-level reference memory predicts every access, and a monitor
// checks SRAM pin activity each stall cycle and the result when ready returns.
module tb_sram_mem_controller;
    localparam int AC = 2;
    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_mem_controller_if mbus ();
    sram_mem_controller_if mbus3 ();

    logic [17:0] sram_addr, sram_addr3;
    logic [15:0] sram_dq_out, sram_dq_in, sram_dq_out3;
    logic        sram_dq_oe, sram_we_n, sram_dq_oe3, sram_we_n3;

    sram_mem_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(AC)) u_dut (
        .clk(clk), .rst(rst), .bus(mbus),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    sram_mem_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(mbus3),
        .sram_addr(sram_addr3), .sram_dq_out(sram_dq_out3), .sram_dq_oe(sram_dq_oe3),
        .sram_dq_in(16'h5A5A), .sram_we_n(sram_we_n3)
    );

    // SRAM model: a halfword is committed only once the strobe has been held on the
    // same address for a full access time; a cut-short access writes nothing.
    logic [15:0] sram_arr [0:262143];
    logic [17:0] w_addr = '0;
    int          w_run = 0;
    assign sram_dq_in = sram_arr[sram_addr];

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) begin
            if (sram_addr == w_addr && w_run != 0) begin
                w_run <= w_run + 1;
                if (w_run + 1 == AC) sram_arr[sram_addr] <= sram_dq_out;
            end else begin
                w_run <= 1;
                if (AC == 1) sram_arr[sram_addr] <= sram_dq_out;
            end
            w_addr <= sram_addr;
        end else begin
            w_run <= 0;
        end
    end

    typedef struct {
        bit          wr;
        logic [16:0] key;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd = '0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] key_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off[18:2];
    endfunction

    // Monitor: k counts stall cycles of the current access (0 = IDLE accept cycle).
    int   mk = 0;
    exp_t me;
    always @(negedge clk) begin
        if (rst) begin
            mk = 0;
        end else if (mbus.mem_r_en || mbus.mem_w_en) begin
            if (!mbus.ready) begin
                if (mk >= 1 && q.size() > 0) begin
                    me = q[0];
                    chk("pins", {14'd0, sram_addr, sram_we_n, sram_dq_oe},
                        {14'd0, me.key, (mk > AC) ? 1'b1 : 1'b0, !me.wr, me.wr});
                    if (me.wr)
                        chk("dq_out", {16'd0, sram_dq_out},
                            {16'd0, (mk > AC) ? me.data[31:16] : me.data[15:0]});
                end
                mk++;
            end else if (mk > 0) begin
                if (q.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    me = q.pop_front();
                    chk("stall_len", mk, 2 * AC + 1);
                    chk("read_data", mbus.read_data, me.exp_rd);
                    chk("done_we_n", {31'd0, sram_we_n}, 32'd1);
                end
                mk = 0;
            end
        end
    end

    task automatic push_exp(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.wr  = w;
        e.key = key_of(a);
        e.data = d;
        if (w) ref_mem[int'(e.key)] = d;
        else if (r) last_rd = ref_mem.exists(int'(e.key)) ? ref_mem[int'(e.key)] : 32'd0;
        e.exp_rd = last_rd;
        q.push_back(e);
    endtask

    // Present a request (caller is #1 after a posedge), hold it through DONE, then drop it.
    task automatic do_access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        int n;
        push_exp(r, w, a, d);
        mbus.mem_r_en = r;  mbus.mem_w_en = w;
        mbus.address = a;   mbus.write_data = d;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (mbus.ready) break;
        end
        if (n == 100) chk("timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        mbus.mem_r_en = 1'b0; mbus.mem_w_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] a, d;
        bit r, w;
        for (int i = 0; i < 262144; i++) sram_arr[i] = 16'h0;
        mbus.mem_r_en = 0; mbus.mem_w_en = 0; mbus.address = 0; mbus.write_data = 0;
        mbus3.mem_r_en = 0; mbus3.mem_w_en = 0; mbus3.address = 0; mbus3.write_data = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle", {mbus.ready, sram_we_n, sram_dq_oe, 11'd0, sram_addr},
                {1'b1, 1'b1, 1'b0, 11'd0, 18'd0});
            chk("idle_rd", mbus.read_data, 32'd0);
        end
        @(posedge clk); #1;

        // Store/load at base; SRAM halfwords checked directly
        do_access(0, 1, 32'd1024, 32'hDEADBEEF);
        chk("sram_h0", {16'd0, sram_arr[0]}, 32'h0000BEEF);
        chk("sram_h1", {16'd0, sram_arr[1]}, 32'h0000DEAD);
        do_access(1, 0, 32'd1024, 32'h0);

        // Address mapping, low address bits ignored
        do_access(1, 0, 32'd1036, 32'h0);
        do_access(1, 0, 32'd1039, 32'h0);

        // Simultaneous enables act as a write
        do_access(1, 1, 32'd1028, 32'h12345678);
        chk("simul_h2", {16'd0, sram_arr[2]}, 32'h00005678);
        chk("simul_h3", {16'd0, sram_arr[3]}, 32'h00001234);

        // Back-to-back: store then preloaded load presented the cycle after DONE
        sram_arr[4] = 16'hCAFE; sram_arr[5] = 16'h0000;
        ref_mem[2] = 32'h0000CAFE;
        do_access(0, 1, 32'd1040, 32'h00000001);
        do_access(1, 0, 32'd1032, 32'h0);

        // Reset in the second HIGH cycle of a store
        push_exp(0, 1, 32'd1024, 32'h11112222);
        ref_mem[0] = 32'hDEAD2222;
        mbus.mem_w_en = 1; mbus.address = 32'd1024; mbus.write_data = 32'h11112222;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        mbus.mem_w_en = 0;
        #1;
        chk("rst_async", {29'd0, sram_we_n, sram_dq_oe, mbus.ready}, {29'd0, 1'b1, 1'b0, 1'b1});
        chk("rst_rd", mbus.read_data, 32'd0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        void'(q.pop_front());
        last_rd = 32'd0;
        do_access(1, 0, 32'd1024, 32'h0);

        // ACCESS_CYCLES=3 instance: 7 stall cycles then data
        mbus3.mem_r_en = 1; mbus3.address = 32'd1024;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mbus3.ready) break;
            n++;
        end
        chk("ac3_stall", n, 7);
        chk("ac3_rd", mbus3.read_data, 32'h5A5A5A5A);
        @(posedge clk); #1 mbus3.mem_r_en = 0;

        // Randomised traffic, including wrap below BASE and both enables
        for (int i = 0; i < 40; i++) begin
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 2) == 0) || !r;
            if ($urandom_range(0, 7) == 0) a = 32'd1024 - 32'($urandom_range(1, 16));
            else a = 32'd1024 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            d = $urandom;
            do_access(r, w, a, d);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        chk("sb_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
